// File: rtl/interfaz_uart.sv
// Register-mapped 8N1 UART: control/TX-data/RX-data registers behind a small
// write port, with an independent serializer on tx_o and deserializer on rx_i.
module interfaz_uart #(
  parameter int BAUD_DIV = 10416
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_i,
  input  logic        reg_sel_i,
  input  logic        addr_i,
  input  logic [31:0] data_i,
  input  logic        rx_i,
  output logic [31:0] mux_o,
  output logic        tx_o
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    T_IDLE  = 2'd0,
    T_START = 2'd1,
    T_DATA  = 2'd2,
    T_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_DATA  = 2'd2,
    R_STOP  = 2'd3
  } rx_state_e;

  tx_state_e        tx_state_q;
  logic [CNT_W-1:0] tx_cnt_q;
  logic [2:0]       tx_idx_q;
  logic [7:0]       tx_shift_q;
  logic [7:0]       tx_data_q;
  logic [7:0]       tx_data_d;
  logic             tx_q;
  logic             send_q;

  rx_state_e        rx_state_q;
  logic [CNT_W-1:0] rx_cnt_q;
  logic [2:0]       rx_idx_q;
  logic [7:0]       rx_shift_q;
  logic [7:0]       rx_data_q;
  logic [7:0]       rx_data_d;
  logic             new_rx_q;
  logic             new_rx_d;
  logic             rx_meta_q;
  logic             rx_sync_q;
  logic             rx_prev_q;

  logic ctl_wr_s;
  logic dat_wr_s;
  logic tx_go_s;
  logic rx_fall_s;
  logic rx_store_s;
  logic unused_data_s;

  assign ctl_wr_s      = wr_i & ~reg_sel_i;
  assign dat_wr_s      = wr_i & reg_sel_i;
  assign tx_go_s       = ctl_wr_s & data_i[0] & (tx_state_q == T_IDLE);
  assign rx_fall_s     = rx_prev_q & ~rx_sync_q;
  assign rx_store_s    = (rx_state_q == R_STOP) & (rx_cnt_q == BIT_LAST) & rx_sync_q;
  assign unused_data_s = ^data_i[31:8];
  assign tx_o          = tx_q;

  // Read mux: selected register, no strobe needed.
  always_comb begin
    mux_o = 32'd0;
    if (!reg_sel_i) begin
      mux_o = {30'd0, new_rx_q, send_q};
    end else if (!addr_i) begin
      mux_o = {24'd0, tx_data_q};
    end else begin
      mux_o = {24'd0, rx_data_q};
    end
  end

  // Next-state for the software-visible data and flag registers.
  always_comb begin
    tx_data_d = tx_data_q;
    rx_data_d = rx_data_q;
    new_rx_d  = new_rx_q;
    if (dat_wr_s && !addr_i) begin
      tx_data_d = data_i[7:0];
    end else begin
      tx_data_d = tx_data_q;
    end
    // A completed frame beats a same-cycle software clear.
    if (rx_store_s) begin
      rx_data_d = rx_shift_q;
      new_rx_d  = 1'b1;
    end else if (ctl_wr_s && !data_i[1]) begin
      new_rx_d  = 1'b0;
    end else begin
      new_rx_d  = new_rx_q;
    end
  end

  // Software-visible register storage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_data_q <= 8'd0;
      rx_data_q <= 8'd0;
      new_rx_q  <= 1'b0;
    end else begin
      tx_data_q <= tx_data_d;
      rx_data_q <= rx_data_d;
      new_rx_q  <= new_rx_d;
    end
  end

  // Transmit FSM: start bit, 8 data bits LSB first, stop bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_state_q <= T_IDLE;
      tx_cnt_q   <= CNT_ZERO;
      tx_idx_q   <= 3'd0;
      tx_shift_q <= 8'd0;
      tx_q       <= 1'b1;
      send_q     <= 1'b0;
    end else begin
      case (tx_state_q)
        T_IDLE: begin
          tx_q <= 1'b1;
          if (tx_go_s) begin
            tx_state_q <= T_START;
            tx_cnt_q   <= CNT_ZERO;
            tx_idx_q   <= 3'd0;
            tx_shift_q <= tx_data_q;
            tx_q       <= 1'b0;
            send_q     <= 1'b1;
          end
        end
        T_START: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q   <= CNT_ZERO;
            tx_state_q <= T_DATA;
            tx_q       <= tx_shift_q[0];
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_ONE;
          end
        end
        T_DATA: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q   <= CNT_ZERO;
            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            if (tx_idx_q == 3'd7) begin
              tx_state_q <= T_STOP;
              tx_q       <= 1'b1;
            end else begin
              tx_idx_q <= tx_idx_q + 3'd1;
              tx_q     <= tx_shift_q[1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_ONE;
          end
        end
        T_STOP: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q   <= CNT_ZERO;
            tx_state_q <= T_IDLE;
            tx_q       <= 1'b1;
            send_q     <= 1'b0;
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_ONE;
          end
        end
        default: begin
          tx_state_q <= T_IDLE;
          tx_cnt_q   <= CNT_ZERO;
          tx_q       <= 1'b1;
          send_q     <= 1'b0;
        end
      endcase
    end
  end

  // Receive path: two-flop synchronizer plus mid-bit sampling FSM.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= R_IDLE;
      rx_cnt_q   <= CNT_ZERO;
      rx_idx_q   <= 3'd0;
      rx_shift_q <= 8'd0;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      case (rx_state_q)
        R_IDLE: begin
          rx_cnt_q <= CNT_ZERO;
          rx_idx_q <= 3'd0;
          if (rx_fall_s) begin
            rx_state_q <= R_START;
          end
        end
        R_START: begin
          // Line back high at mid start bit means it was a glitch.
          if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_q   <= CNT_ZERO;
            rx_state_q <= rx_sync_q ? R_IDLE : R_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_ONE;
          end
        end
        R_DATA: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q   <= CNT_ZERO;
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            if (rx_idx_q == 3'd7) begin
              rx_state_q <= R_STOP;
            end else begin
              rx_idx_q <= rx_idx_q + 3'd1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_ONE;
          end
        end
        R_STOP: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q   <= CNT_ZERO;
            rx_state_q <= R_IDLE;
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_ONE;
          end
        end
        default: begin
          rx_state_q <= R_IDLE;
          rx_cnt_q   <= CNT_ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interfaz_uart.sv
// Randomized bench for interfaz_uart with a frame-level reference model of the
// registers and of 8N1 serial timing.
module tb_interfaz_uart;

  localparam int BD = 16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        wr_i;
  logic        reg_sel_i;
  logic        addr_i;
  logic [31:0] data_i;
  logic        rx_i;
  logic [31:0] mux_o;
  logic        tx_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_tx_data;
  logic [7:0] m_rx_data;
  logic       m_new_rx;

  interfaz_uart #(.BAUD_DIV(BD)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_i      (wr_i),
    .reg_sel_i (reg_sel_i),
    .addr_i    (addr_i),
    .data_i    (data_i),
    .rx_i      (rx_i),
    .mux_o     (mux_o),
    .tx_o      (tx_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic sel, input logic a, input logic [31:0] exp);
    reg_sel_i = sel;
    addr_i    = a;
    #1;
    check_val(tag, mux_o, exp);
    reg_sel_i = 1'b0;
    addr_i    = 1'b0;
  endtask

  task automatic wr_reg(input logic sel, input logic a, input logic [31:0] d);
    wr_i = 1'b1; reg_sel_i = sel; addr_i = a; data_i = d;
    @(posedge clk_i); #1;
    wr_i = 1'b0; reg_sel_i = 1'b0; addr_i = 1'b0; data_i = 32'd0;
  endtask

  // Start a frame with the modelled TX byte and check every cycle of it.
  task automatic tx_frame(input logic meddle, input logic [7:0] nb);
    logic [9:0] fr;
    fr = {1'b1, m_tx_data, 1'b0};
    wr_i = 1'b1; reg_sel_i = 1'b0; data_i = 32'd1;
    @(posedge clk_i); #1;
    m_new_rx = 1'b0;
    for (int t = 0; t < 10 * BD; t++) begin
      wr_i = 1'b0; reg_sel_i = 1'b0; addr_i = 1'b0; data_i = 32'd0;
      #1;
      check_val("tx_bit", {31'd0, tx_o}, {31'd0, fr[t / BD]});
      check_val("ctl_busy", mux_o, {30'd0, m_new_rx, 1'b1});
      if (meddle && t == 40) begin
        wr_i = 1'b1; data_i = 32'd1;
      end
      if (meddle && t == 60) begin
        wr_i = 1'b1; reg_sel_i = 1'b1; data_i = {24'd0, nb};
      end
      @(posedge clk_i); #1;
      if (meddle && t == 40) m_new_rx = 1'b0;
      if (meddle && t == 60) m_tx_data = nb;
    end
    wr_i = 1'b0; reg_sel_i = 1'b0; data_i = 32'd0;
    #1;
    check_val("tx_idle", {31'd0, tx_o}, 32'd1);
    check_reg("ctl_done", 1'b0, 1'b0, {30'd0, m_new_rx, 1'b0});
  endtask

  // Drive one serial frame on rx_i; flag must rise 154 edges after the start edge.
  task automatic rx_frame(input logic [7:0] b, input logic stop_ok, input logic clr);
    logic [9:0] fr;
    fr = {stop_ok, b, 1'b0};
    for (int c = 0; c < 10 * BD; c++) begin
      rx_i = fr[c / BD];
      if (clr && c == 154) begin
        wr_i = 1'b1; reg_sel_i = 1'b0; data_i = 32'd0;
      end
      @(posedge clk_i); #1;
      wr_i = 1'b0; reg_sel_i = 1'b0; data_i = 32'd0;
      if (c == 153) check_reg("rx_pre", 1'b0, 1'b0, {30'd0, m_new_rx, 1'b0});
      if (c == 154) begin
        if (stop_ok) begin
          m_rx_data = b;
          m_new_rx  = 1'b1;
        end else if (clr) begin
          m_new_rx  = 1'b0;
        end
        check_reg("rx_flag", 1'b0, 1'b0, {30'd0, m_new_rx, 1'b0});
      end
    end
    rx_i = 1'b1;
    check_reg("rx_data", 1'b1, 1'b1, {24'd0, m_rx_data});
  endtask

  initial begin
    logic [7:0] b;
    rst_i = 1'b1; wr_i = 1'b0; reg_sel_i = 1'b0; addr_i = 1'b0;
    data_i = 32'd0; rx_i = 1'b1;
    m_tx_data = 8'd0; m_rx_data = 8'd0; m_new_rx = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    check_val("rst_tx", {31'd0, tx_o}, 32'd1);
    check_reg("rst_ctl", 1'b0, 1'b0, 32'd0);
    check_reg("rst_txd", 1'b1, 1'b0, 32'd0);
    check_reg("rst_rxd", 1'b1, 1'b1, 32'd0);

    wr_reg(1'b1, 1'b0, 32'h0000_00A5);
    m_tx_data = 8'hA5;
    check_reg("txd_rd", 1'b1, 1'b0, 32'h0000_00A5);
    wr_reg(1'b1, 1'b1, 32'h0000_0077);
    check_reg("rxd_ro", 1'b1, 1'b1, 32'd0);
    tx_frame(1'b1, 8'h3C);
    check_reg("txd_new", 1'b1, 1'b0, 32'h0000_003C);
    tx_frame(1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom_range(0, 255));
      wr_reg(1'b1, 1'b0, {24'd0, b});
      m_tx_data = b;
      repeat ($urandom_range(0, 3)) @(posedge clk_i);
      #1;
      tx_frame(1'b0, 8'h00);
    end

    rx_frame(8'h5A, 1'b1, 1'b0);
    wr_reg(1'b0, 1'b0, 32'd0);
    m_new_rx = 1'b0;
    check_reg("ctl_clr", 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      rx_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0), 1'b0);
      repeat (2) @(posedge clk_i);
      #1;
    end

    wr_reg(1'b0, 1'b0, 32'd0);
    m_new_rx = 1'b0;
    rx_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    rx_i = 1'b1;
    repeat (200) @(posedge clk_i);
    #1;
    check_reg("glitch_ctl", 1'b0, 1'b0, 32'd0);
    check_reg("glitch_rxd", 1'b1, 1'b1, {24'd0, m_rx_data});
    b = m_rx_data ^ 8'hFF;
    rx_frame(b, 1'b0, 1'b0);
    repeat (8) @(posedge clk_i);
    #1;
    rx_frame(8'($urandom_range(0, 255)), 1'b1, 1'b1);

    b = 8'($urandom_range(0, 255));
    wr_reg(1'b1, 1'b0, {24'd0, b});
    wr_reg(1'b0, 1'b0, 32'h0000_0003);
    repeat (50) @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    #1;
    check_val("rst_mid_tx", {31'd0, tx_o}, 32'd1);
    check_reg("rst_mid_ctl", 1'b0, 1'b0, 32'd0);
    check_reg("rst_mid_txd", 1'b1, 1'b0, 32'd0);
    check_reg("rst_mid_rxd", 1'b1, 1'b1, 32'd0);
    m_tx_data = 8'd0; m_rx_data = 8'd0; m_new_rx = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    b = 8'($urandom_range(0, 255));
    wr_reg(1'b1, 1'b0, {24'd0, b});
    m_tx_data = b;
    tx_frame(1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/interfaz_uart.md
Name: interfaz_uart

Overview:
Register-mapped 8N1 UART peripheral driven by the test-control FSM through wr_i/reg_sel_i/addr_i/data_i. It returns read data on mux_o.
- Control register: send-request bit and receive-flag bit.
- TX data register and RX data register.
- Serializer drives tx_o; deserializer samples rx_i.

Parameters:
BAUD_DIV, 10416, clock cycles per UART bit (100 MHz / 9600 baud); legal range >= 4.

Ports:
clk_i  in  1  system clock; all state on rising edge
rst_i  in  1  asynchronous reset, active-high
wr_i  in  1  write strobe, one-cycle pulse, sampled on rising edge
reg_sel_i  in  1  0 = control register, 1 = data registers
addr_i  in  1  data-register select when reg_sel_i=1: 0 = TX data, 1 = RX data
data_i  in  32  write data
rx_i  in  1  serial input, asynchronous to clk_i, idles high
mux_o  out  32  combinational read data of the selected register
tx_o  out  1  serial output, idles high

Behaviour:
- Reset (async assert, sync-free release):
  - tx_o=1, send=0, new_rx=0, tx_data=0, rx_data=0.
  - TX FSM = T_IDLE, RX FSM = R_IDLE, all counters 0.
  - Two-flop rx_i synchronizer preset to 1.
- Reset mid-frame aborts both FSMs immediately. tx_o returns to 1 asynchronously.
- Read mux (combinational, no wr_i needed):
  - reg_sel_i=0: {30'd0, new_rx, send}.
  - reg_sel_i=1, addr_i=0: {24'd0, tx_data}.
  - reg_sel_i=1, addr_i=1: {24'd0, rx_data}.
- Control write (wr_i=1, reg_sel_i=0):
  - data_i[0]=1 and TX idle: set send, latch tx_data into TX shift register, TX FSM -> T_START next cycle.
  - data_i[0]=1 while TX busy: ignored. data_i[0]=0: no effect (no abort).
  - data_i[1]=0 clears new_rx. data_i[1]=1 has no effect (software cannot set new_rx).
  - Hence writing 0x1 both starts TX and clears new_rx; writing 0x0 only clears new_rx.
- Data write (wr_i=1, reg_sel_i=1):
  - addr_i=0: tx_data <= data_i[7:0], allowed while busy; the frame in flight is unaffected.
  - addr_i=1: ignored (RX data is read-only).
- TX FSM (T_IDLE, T_START, T_DATA, T_STOP):
  - Baud counter counts 0..BAUD_DIV-1 per bit.
  - T_START: tx_o=0 for BAUD_DIV cycles.
  - T_DATA: 8 bits LSB first, BAUD_DIV cycles each, 3-bit index.
  - T_STOP: tx_o=1 for BAUD_DIV cycles.
  - At end of stop bit: send <= 0, FSM -> T_IDLE.
  - tx_o falls on the first clock edge after the accepted write. Frame length is exactly 10*BAUD_DIV cycles. send reads 1 for that whole interval.
- RX FSM (R_IDLE, R_START, R_DATA, R_STOP), on the synchronized rx (2-cycle latency):
  - R_IDLE: a falling edge (sync 1->0) enters R_START.
  - R_START: after BAUD_DIV/2 cycles, rx still 0 -> R_DATA; rx = 1 -> glitch, back to R_IDLE.
  - R_DATA: sample every BAUD_DIV cycles (mid-bit), shift in LSB first, 8 samples.
  - R_STOP: sample after BAUD_DIV cycles.
    - Sample = 1: rx_data <= shifted byte, new_rx <= 1.
    - Sample = 0 (framing error): byte discarded, rx_data and new_rx unchanged.
    - Either way -> R_IDLE.
  - A new byte overwrites rx_data even if new_rx is already 1 (no overrun flag).
- Simultaneous events:
  - RX setting new_rx and a control write clearing it in the same cycle: the set wins.
  - TX and RX run fully independently (full duplex). Loopback tx_o->rx_i is legal.

Test Plan:
- BAUD_DIV=16 for all scenarios.
- Reset, then read each register -> mux_o=0 for all three; tx_o=1.
- Write 0xA5 to TX data (reg_sel_i=1, addr_i=0), then write 0x1 to control:
  - tx_o low on the next edge for 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then 1.
  - Control reads 0x1 for 160 cycles, then 0x0.
- Write 0x1 to control again mid-frame, and write 0x3C to TX data mid-frame:
  - Frame still transmits 0xA5, with no restart.
  - Next send transmits 0x3C.
- Drive a 0x5A frame on rx_i -> ~2+152 cycles after the start edge, new_rx=1; the RX data read returns 0x0000005A. Then write 0x0 to control -> control reads 0x0.
- rx_i low for 4 cycles only (glitch) -> no frame, new_rx stays 0. A frame with stop bit 0 -> rx_data unchanged, new_rx stays 0.
- Assert rst_i mid TX frame -> tx_o=1 immediately, control reads 0. Align a clearing control write with the RX stop-bit sample cycle -> new_rx=1.
